ahbl_exclusive_monitor: RTL and testbench
=========================================

// Module: ahbl_exclusive_monitor
// PURPOSE
//  AHB5-style global exclusive-access monitor. Sits between one crossbar slave port (dst_*) and one memory slave.
//  Tracks one reservation per master and decides pass or fail for each exclusive write.
//  Suppresses failed exclusive writes downstream and drives HEXOKAY back toward the crossbar.
//  Otherwise a transparent AHB-Lite pass-through, adding zero cycles of latency.
// PARAMETERS
//  N_MASTERS    2   number of reservation slots; slot index = src_hmaster[IDXW-1:0], IDXW = max(1,clog2(N_MASTERS))
//  W_ADDR       32  address width
//  W_DATA       32  data width
//  GRANULE_LOG2 3   reservation granule = 2**GRANULE_LOG2 bytes; compare src_haddr[W_ADDR-1:GRANULE_LOG2]
// PORTS
//  clk              in   1       system clock
//  rst_n            in   1       asynchronous active-low reset
//  src_hready       in   1       upstream HREADY (from crossbar dst_hready)
//  src_hready_resp  out  1       = dst_hready_resp
//  src_hresp        out  1       = dst_hresp
//  src_haddr/hwrite/htrans/hsize/hburst/hprot/hmastlock  in  W_ADDR/1/2/3/3/4/1  upstream address phase
//  src_hwdata       in   W_DATA  write data
//  src_hrdata       out  W_DATA  = dst_hrdata
//  src_hexcl        in   1       exclusive transfer qualifier (address phase)
//  src_hmaster      in   8       master ID (address phase)
//  src_hexokay      out  1       exclusive success (data phase, valid while src_hready_resp=1)
//  dst_hready       out  1       = src_hready
//  dst_hready_resp  in   1       slave HREADYOUT
//  dst_hresp        in   1       slave HRESP
//  dst_haddr/hwrite/hsize/hburst/hprot/hmastlock/hwdata  out  passthrough from src_*
//  dst_htrans       out  2       = src_htrans, or 2'b00 (IDLE) when suppressing a write
//  dst_hrdata       in   W_DATA  slave read data
// BEHAVIOUR
//  Address phase accepted when src_hready & src_htrans[1]. All reservation updates happen only on acceptance.
//  Reservation entry = {valid, granule tag}. At reset all entries are invalid and data-phase regs are cleared.
//  Reset value of src_hexokay is 0. Mid-transfer reset drops all reservations.
//  Slot index valid iff src_hmaster < N_MASTERS. An exclusive from an out-of-range ID always fails and sets no entry.
//  Accepted exclusive read: slot <= {1, tag}, overwriting any prior entry. Data phase: src_hexokay = ~dst_hresp.
//   On dst_hresp=1 the slot is invalidated at data-phase completion.
//  Accepted exclusive write, own slot valid and tag match: pass through unmodified.
//   Data phase: src_hexokay = ~dst_hresp. Own slot is cleared.
//  Accepted exclusive write, no match: dst_htrans forced to IDLE the same cycle. Slave then gives a zero-wait OKAY.
//   Data phase: src_hexokay = 0, write is dropped, own slot is cleared.
//  Any write actually forwarded (normal or successful exclusive) clears every slot whose tag matches, own slot included.
//  Non-exclusive read: no slot change; src_hexokay = 0.
//  Data-phase regs (excl_dp, okay_dp) load on acceptance and clear on an accepted IDLE/BUSY.
//   They hold while src_hready=0. src_hexokay = okay_dp & src_hready_resp & ~dst_hresp.
//  A clear and a set to the same slot cannot coincide (one address phase per cycle). Priority: set over clear.
//  No added wait states. Combinational paths: src_htrans/hexcl/hmaster/haddr -> dst_htrans (slot compare).
// CONFIGURATION
//  EXMON_STATS_EN defined: adds ports
//   stat_pass  out 16  saturating count of successful exclusive writes
//   stat_fail  out 16  saturating count of failed exclusive writes
//   Both reset to 0, update at data-phase completion, and hold at 16'hffff.
//  EXMON_STATS_EN undefined: those ports and counters are absent.
// STRUCTURE
//  Shared header ahbl_defs.vh: HTRANS_IDLE/BUSY/NONSEQ/SEQ, HRESP_OKAY/ERROR, W_HMASTER=8.
//  Sub-module ahbl_exmon_slot: one reservation entry.
//   Inputs: set, clr_own, snoop_wr, tag_in.
//   Outputs: valid, match. Instantiated N_MASTERS times in a generate loop.
// TESTING
//  T1: M0 excl read 0x100, then excl write 0x104 (granule 8) -> write forwarded, hexokay=1, slot0 invalid.
//  T2: M0 excl read 0x100; M1 normal write 0x100; M0 excl write 0x100 -> dst_htrans=IDLE, hexokay=0, mem unchanged.
//  T3: M0 and M1 excl read 0x200; M1 excl write passes -> M0 excl write 0x200 fails (snoop clear).
//  T4: excl write with no prior read, and hmaster=8'h05 with N_MASTERS=2 -> both fail, no dst write.
//  T5: excl read with slave wait states (3 cycles) then HRESP error -> hexokay=0 throughout, next excl write fails.
//  T6: assert rst_n low between excl read and write -> write fails; EXMON_STATS_EN build: stat_fail increments 0->1.

Source files
------------

// File: rtl/ahbl_exclusive_monitor_pkg.sv
// Shared AHB-Lite encodings and helpers for the exclusive-access monitor.
// Holds the HTRANS/HRESP codes, the master-ID width and the slot-index width helper.
package ahbl_exclusive_monitor_pkg;

   localparam int W_HMASTER = 8;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ahbl_exmon_slot.sv
// One reservation entry of the exclusive monitor: a valid flag plus a granule tag.
// A set always wins over an own clear or a snooped-write clear in the same cycle.
module ahbl_exmon_slot #(
   parameter int W_TAG = 29
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             set,
   input  logic             clr_own,
   input  logic             snoop_wr,
   input  logic [W_TAG-1:0] tag_in,
   output logic             valid,
   output logic             match
);

   logic [W_TAG-1:0] tag_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         tag_q <= '0;
      end else if (set) begin
         valid <= 1'b1;
         tag_q <= tag_in;
      end else if (clr_own || (snoop_wr && match)) begin
         valid <= 1'b0;
      end
   end

   assign match = valid && (tag_q == tag_in);

endmodule

// File: rtl/ahbl_exclusive_monitor.sv
// Global exclusive-access monitor between a crossbar port and one memory slave.
// Optional build macro EXMON_STATS_EN adds saturating pass/fail counters (stat_pass, stat_fail).
module ahbl_exclusive_monitor
   import ahbl_exclusive_monitor_pkg::*;
#(
   parameter int N_MASTERS    = 2,
   parameter int W_ADDR       = 32,
   parameter int W_DATA       = 32,
   parameter int GRANULE_LOG2 = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 src_hready,
   output logic                 src_hready_resp,
   output logic                 src_hresp,
   input  logic [W_ADDR-1:0]    src_haddr,
   input  logic                 src_hwrite,
   input  logic [1:0]           src_htrans,
   input  logic [2:0]           src_hsize,
   input  logic [2:0]           src_hburst,
   input  logic [3:0]           src_hprot,
   input  logic                 src_hmastlock,
   input  logic [W_DATA-1:0]    src_hwdata,
   input  logic                 src_hexcl,
   input  logic [W_HMASTER-1:0] src_hmaster,
   output logic                 src_hexokay,
   output logic                 dst_hready,
   input  logic                 dst_hready_resp,
   input  logic                 dst_hresp,
   output logic [W_ADDR-1:0]    dst_haddr,
   output logic                 dst_hwrite,
   output logic [1:0]           dst_htrans,
   output logic [2:0]           dst_hsize,
   output logic [2:0]           dst_hburst,
   output logic [3:0]           dst_hprot,
   output logic                 dst_hmastlock,
   output logic [W_DATA-1:0]    dst_hwdata,
   input  logic [W_DATA-1:0]    dst_hrdata,
`ifdef EXMON_STATS_EN
   output logic [15:0]          stat_pass,
   output logic [15:0]          stat_fail,
`endif
   output logic [W_DATA-1:0]    src_hrdata
);

   localparam int IDXW  = idx_width(N_MASTERS);
   localparam int W_TAG = W_ADDR - GRANULE_LOG2;

   logic [W_TAG-1:0]     tag;
   logic [IDXW-1:0]      idx;
   logic                 idx_ok;
   logic                 accept;
   logic                 excl_wr_acc;
   logic                 own_match;
   logic                 suppress;
   logic                 fwd_wr;
   logic                 okay_nxt;
   logic                 err_clr;
   logic [N_MASTERS-1:0] set_vec;
   logic [N_MASTERS-1:0] clr_vec;
   logic [N_MASTERS-1:0] valid_vec;
   logic [N_MASTERS-1:0] match_vec;

   logic                 excl_dp;
   logic                 wr_dp;
   logic                 okay_dp;
   logic [IDXW-1:0]      idx_dp;
   logic                 idx_ok_dp;

   assign src_hready_resp = dst_hready_resp;
   assign src_hresp       = dst_hresp;
   assign src_hrdata      = dst_hrdata;
   assign dst_hready      = src_hready;
   assign dst_haddr       = src_haddr;
   assign dst_hwrite      = src_hwrite;
   assign dst_hsize       = src_hsize;
   assign dst_hburst      = src_hburst;
   assign dst_hprot       = src_hprot;
   assign dst_hmastlock   = src_hmastlock;
   assign dst_hwdata      = src_hwdata;

   assign tag         = src_haddr[W_ADDR-1:GRANULE_LOG2];
   assign idx         = src_hmaster[IDXW-1:0];
   assign idx_ok      = (32'(src_hmaster) < 32'(N_MASTERS));
   assign accept      = src_hready && src_htrans[1];
   assign excl_wr_acc = accept && src_hexcl && src_hwrite;
   assign own_match   = idx_ok && match_vec[idx];
   assign suppress    = excl_wr_acc && !own_match;
   assign fwd_wr      = accept && src_hwrite && !suppress;
   assign okay_nxt    = src_hexcl && (src_hwrite ? own_match : idx_ok);
   assign dst_htrans  = suppress ? HTRANS_IDLE : src_htrans;

   // A failed exclusive read drops its reservation once the error response completes.
   assign err_clr = src_hready && excl_dp && !wr_dp && idx_ok_dp && (dst_hresp == HRESP_ERROR);

   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      for (int i = 0; i < N_MASTERS; i++) begin
         if (idx_ok && (idx == IDXW'(i))) begin
            set_vec[i] = accept && src_hexcl && !src_hwrite;
            clr_vec[i] = excl_wr_acc;
         end
         if (err_clr && (idx_dp == IDXW'(i))) begin
            clr_vec[i] = 1'b1;
         end
      end
   end

   for (genvar i = 0; i < N_MASTERS; i++) begin : g_slot
      ahbl_exmon_slot #(.W_TAG(W_TAG)) u_slot (
         .clk      (clk),
         .rst_n    (rst_n),
         .set      (set_vec[i]),
         .clr_own  (clr_vec[i]),
         .snoop_wr (fwd_wr),
         .tag_in   (tag),
         .valid    (valid_vec[i]),
         .match    (match_vec[i])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         excl_dp   <= 1'b0;
         wr_dp     <= 1'b0;
         okay_dp   <= 1'b0;
         idx_dp    <= '0;
         idx_ok_dp <= 1'b0;
      end else if (src_hready) begin
         if (src_htrans[1]) begin
            excl_dp   <= src_hexcl;
            wr_dp     <= src_hwrite;
            okay_dp   <= okay_nxt;
            idx_dp    <= idx;
            idx_ok_dp <= idx_ok;
         end else begin
            excl_dp   <= 1'b0;
            wr_dp     <= 1'b0;
            okay_dp   <= 1'b0;
            idx_ok_dp <= 1'b0;
         end
      end
   end

   assign src_hexokay = okay_dp && dst_hready_resp && (dst_hresp == HRESP_OKAY);

`ifdef EXMON_STATS_EN
   logic wr_done;
   logic wr_pass;

   assign wr_done = src_hready && excl_dp && wr_dp;
   assign wr_pass = okay_dp && (dst_hresp == HRESP_OKAY);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_pass <= '0;
         stat_fail <= '0;
      end else if (wr_done) begin
         if (wr_pass && (stat_pass != 16'hffff)) stat_pass <= stat_pass + 16'd1;
         if (!wr_pass && (stat_fail != 16'hffff)) stat_fail <= stat_fail + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ahbl_exclusive_monitor.sv
// Self-checking bench for ahbl_exclusive_monitor: directed scenarios followed by random traffic,
// checked against a reservation/memory model that works on granule addresses and per-master flags.
module tb_ahbl_exclusive_monitor;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        src_hready;
   logic        src_hready_resp;
   logic        src_hresp;
   logic [31:0] src_haddr = '0;
   logic        src_hwrite = 1'b0;
   logic [1:0]  src_htrans = 2'b00;
   logic [31:0] src_hwdata = '0;
   logic        src_hexcl = 1'b0;
   logic [7:0]  src_hmaster = '0;
   logic        src_hexokay;
   logic        dst_hready;
   logic        dst_hready_resp;
   logic        dst_hresp;
   logic [31:0] dst_haddr;
   logic        dst_hwrite;
   logic [1:0]  dst_htrans;
   logic [2:0]  dst_hsize;
   logic [2:0]  dst_hburst;
   logic [3:0]  dst_hprot;
   logic        dst_hmastlock;
   logic [31:0] dst_hwdata;
   logic [31:0] src_hrdata;
`ifdef EXMON_STATS_EN
   logic [15:0] stat_pass;
   logic [15:0] stat_fail;
`endif

   int checks = 0;
   int errors = 0;

   ahbl_exclusive_monitor dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .src_hready      (src_hready),
      .src_hready_resp (src_hready_resp),
      .src_hresp       (src_hresp),
      .src_haddr       (src_haddr),
      .src_hwrite      (src_hwrite),
      .src_htrans      (src_htrans),
      .src_hsize       (3'b010),
      .src_hburst      (3'b000),
      .src_hprot       (4'b0011),
      .src_hmastlock   (1'b0),
      .src_hwdata      (src_hwdata),
      .src_hexcl       (src_hexcl),
      .src_hmaster     (src_hmaster),
      .src_hexokay     (src_hexokay),
      .dst_hready      (dst_hready),
      .dst_hready_resp (dst_hready_resp),
      .dst_hresp       (dst_hresp),
      .dst_haddr       (dst_haddr),
      .dst_hwrite      (dst_hwrite),
      .dst_htrans      (dst_htrans),
      .dst_hsize       (dst_hsize),
      .dst_hburst      (dst_hburst),
      .dst_hprot       (dst_hprot),
      .dst_hmastlock   (dst_hmastlock),
      .dst_hwdata      (dst_hwdata),
      .dst_hrdata      (32'h0),
`ifdef EXMON_STATS_EN
      .stat_pass       (stat_pass),
      .stat_fail       (stat_fail),
`endif
      .src_hrdata      (src_hrdata)
   );

   always #5 clk = ~clk;

   // Simple memory slave with programmable wait states and two-cycle ERROR response.
   logic        s_act = 1'b0;
   logic        s_wr = 1'b0;
   logic [31:0] s_addr = '0;
   int          s_wait = 0;
   logic        s_err = 1'b0;
   logic        s_err2 = 1'b0;
   int          cfg_wait = 0;
   logic        cfg_err = 1'b0;
   logic [31:0] mem [0:255];

   assign src_hready = dst_hready_resp;

   always_comb begin
      dst_hready_resp = 1'b1;
      dst_hresp       = 1'b0;
      if (s_act) begin
         if (s_wait > 0) dst_hready_resp = 1'b0;
         else if (s_err && !s_err2) begin
            dst_hready_resp = 1'b0;
            dst_hresp       = 1'b1;
         end else if (s_err) dst_hresp = 1'b1;
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_act  <= 1'b0;
         s_wait <= 0;
         s_err  <= 1'b0;
         s_err2 <= 1'b0;
      end else if (dst_hready) begin
         if (s_act && s_wr && !s_err) mem[s_addr[9:2]] <= dst_hwdata;
         s_act  <= dst_htrans[1];
         s_wr   <= dst_hwrite;
         s_addr <= dst_haddr;
         s_wait <= cfg_wait;
         s_err  <= cfg_err;
         s_err2 <= 1'b0;
      end else if (s_wait > 0) begin
         s_wait <= s_wait - 1;
      end else if (s_err) begin
         s_err2 <= 1'b1;
      end
   end

   // Reference model: one reservation (granule address) per in-range master, plus expected memory.
   bit          res_v [2];
   logic [28:0] res_g [2];
   logic [31:0] mem_m [0:255];
   bit          mem_w [0:255];
   int          cnt_pass = 0;
   int          cnt_fail = 0;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] m, input logic [31:0] addr, input bit wr,
                                input bit excl, input logic [31:0] data, input int wt, input bit err);
      bit          idx_ok;
      bit          pass;
      bit          fwd;
      bit          eff_err;
      bit          exp_okay;
      logic [28:0] g;
      int          cycles;
      idx_ok   = (m < 8'd2);
      g        = addr[31:3];
      pass     = excl && wr && idx_ok && res_v[m[0]] && (res_g[m[0]] == g);
      fwd      = !(excl && wr) || pass;
      eff_err  = err && fwd;
      exp_okay = excl && (wr ? pass : idx_ok) && !eff_err;

      @(negedge clk);
      cfg_wait    = fwd ? wt : 0;
      cfg_err     = eff_err;
      src_hmaster = m;
      src_haddr   = addr;
      src_hwrite  = wr;
      src_hexcl   = excl;
      src_htrans  = 2'b10;
      #1;
      checkOutput("dst_htrans", {30'b0, dst_htrans}, fwd ? 32'd2 : 32'd0);
      checkOutput("dst_haddr", dst_haddr, addr);
      @(posedge clk);
      @(negedge clk);
      src_htrans = 2'b00;
      src_hexcl  = 1'b0;
      src_hwdata = data;
      cycles     = 0;
      while (!src_hready_resp && cycles < 20) begin
         checkOutput("hexokay_wait", {31'b0, src_hexokay}, 32'd0);
         @(negedge clk);
         cycles++;
      end
      checkOutput("dp_done", {31'b0, src_hready_resp}, 32'd1);
      checkOutput("hexokay", {31'b0, src_hexokay}, {31'b0, exp_okay});
      @(posedge clk);

      if (fwd && wr) begin
         for (int j = 0; j < 2; j++)
            if (res_v[j] && res_g[j] == g) res_v[j] = 1'b0;
         if (!eff_err) begin
            mem_m[addr[9:2]] = data;
            mem_w[addr[9:2]] = 1'b1;
         end
      end
      if (excl && idx_ok) begin
         if (wr) res_v[m[0]] = 1'b0;
         else begin
            res_v[m[0]] = !eff_err;
            res_g[m[0]] = g;
         end
      end
      if (excl && wr) begin
         if (exp_okay) cnt_pass++;
         else cnt_fail++;
      end
   endtask

   task automatic doReset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      res_v[0] = 1'b0;
      res_v[1] = 1'b0;
      cnt_pass = 0;
      cnt_fail = 0;
      #1;
      checkOutput("rst_hexokay", {31'b0, src_hexokay}, 32'd0);
   endtask

   initial begin
      logic [31:0] pool [4];
      pool[0] = 32'h100; pool[1] = 32'h104; pool[2] = 32'h108; pool[3] = 32'h200;
      for (int i = 0; i < 256; i++) mem_w[i] = 1'b0;

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("reset_hexokay", {31'b0, src_hexokay}, 32'd0);
      checkOutput("reset_dst_htrans", {30'b0, dst_htrans}, 32'd0);
`ifdef EXMON_STATS_EN
      checkOutput("reset_stat_pass", {16'b0, stat_pass}, 32'd0);
      checkOutput("reset_stat_fail", {16'b0, stat_fail}, 32'd0);
`endif

      // T1: same-granule exclusive pair succeeds and consumes the reservation
      applyStimulus(8'd0, 32'h100, 1'b0, 1'b1, 32'h0, 0, 1'b0);
      applyStimulus(8'd0, 32'h104, 1'b1, 1'b1, 32'h1111_0001, 0, 1'b0);
      applyStimulus(8'd0, 32'h104, 1'b1, 1'b1, 32'h1111_0002, 0, 1'b0);
      checkOutput("t1_mem", mem[8'h41], 32'h1111_0001);

      // T2: another master's normal write kills the reservation
      applyStimulus(8'd0, 32'h100, 1'b0, 1'b1, 32'h0, 0, 1'b0);
      applyStimulus(8'd1, 32'h100, 1'b1, 1'b0, 32'h2222_0001, 0, 1'b0);
      applyStimulus(8'd0, 32'h100, 1'b1, 1'b1, 32'h2222_0002, 0, 1'b0);
      checkOutput("t2_mem", mem[8'h40], 32'h2222_0001);

      // T3: two readers, first writer wins, second fails
      applyStimulus(8'd0, 32'h200, 1'b0, 1'b1, 32'h0, 0, 1'b0);
      applyStimulus(8'd1, 32'h200, 1'b0, 1'b1, 32'h0, 1, 1'b0);
      applyStimulus(8'd1, 32'h200, 1'b1, 1'b1, 32'h3333_0001, 0, 1'b0);
      applyStimulus(8'd0, 32'h200, 1'b1, 1'b1, 32'h3333_0002, 0, 1'b0);
      checkOutput("t3_mem", mem[8'h80], 32'h3333_0001);

      // T4: no prior read, and out-of-range master
      applyStimulus(8'd1, 32'h108, 1'b1, 1'b1, 32'h4444_0001, 0, 1'b0);
      applyStimulus(8'd5, 32'h108, 1'b0, 1'b1, 32'h0, 0, 1'b0);
      applyStimulus(8'd5, 32'h108, 1'b1, 1'b1, 32'h4444_0002, 0, 1'b0);

      // T5: exclusive read with wait states and error response
      applyStimulus(8'd0, 32'h108, 1'b0, 1'b1, 32'h0, 3, 1'b1);
      applyStimulus(8'd0, 32'h108, 1'b1, 1'b1, 32'h5555_0001, 0, 1'b0);

      // T6: reset between exclusive read and write
      applyStimulus(8'd1, 32'h100, 1'b0, 1'b1, 32'h0, 0, 1'b0);
      doReset();
      applyStimulus(8'd1, 32'h100, 1'b1, 1'b1, 32'h6666_0001, 0, 1'b0);
`ifdef EXMON_STATS_EN
      checkOutput("t6_stat_fail", {16'b0, stat_fail}, cnt_fail);
`endif

      for (int n = 0; n < 200; n++) begin
         logic [7:0] m;
         m = ($urandom_range(0, 7) == 0) ? 8'd5 : 8'($urandom_range(0, 1));
         applyStimulus(m, pool[$urandom_range(0, 3)], 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 3) != 0), $urandom, $urandom_range(0, 2),
                       ($urandom_range(0, 7) == 0));
      end

      for (int i = 0; i < 4; i++)
         if (mem_w[pool[i][9:2]]) checkOutput("final_mem", mem[pool[i][9:2]], mem_m[pool[i][9:2]]);
`ifdef EXMON_STATS_EN
      checkOutput("final_stat_pass", {16'b0, stat_pass}, cnt_pass);
      checkOutput("final_stat_fail", {16'b0, stat_fail}, cnt_fail);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
